// File: rtl/dff_edge_debouncer.sv
// Two-flop synchronizer followed by a stability-count debouncer.
// Produces a clean level q plus registered single-cycle rise/fall pulses.
module dff_edge_debouncer #(
   parameter int STABLE = 4,
   parameter int CW     = 3
) (
   input  logic clk,
   input  logic clr,
   input  logic din,
   input  logic en,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy
);

   // Handshake: none. Every input is sampled on each rising clk edge; en
   // qualifies only the debounce state, never the synchronizer.

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          s1_q, s2_q;
   logic          q_q, q_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Only s1_q may go metastable; nothing downstream looks at it.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= din;
         s2_q <= s1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (s2_q != q_q) begin
                  if (STABLE == 1) begin
                     q_d    = s2_q;
                     rise_d = s2_q;
                     fall_d = ~s2_q;
                  end else begin
                     state_d = COUNT;
                     cnt_d   = CW'(1);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            COUNT: begin
               if (s2_q == q_q) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  q_d     = s2_q;
                  rise_d  = s2_q;
                  fall_d  = ~s2_q;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // busy is the externally visible FSM state: high exactly in COUNT.
   assign busy = (state_q == COUNT);
   assign q    = q_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule
